// File: rtl/input_key_start_if.sv
// Board-side key/start handshake between the push-button front end and the inference controller.
// The master drives the raw key and controller readiness; the slave returns the debounced level and start request.
interface input_key_start_if;
    logic key_in;
    logic ready;
    logic key_state;
    logic start;
    logic pending;

    modport master (
        output key_in,
        output ready,
        input  key_state,
        input  start,
        input  pending
    );

    modport slave (
        input  key_in,
        input  ready,
        output key_state,
        output start,
        output pending
    );
endinterface

// File: rtl/input_key_start.sv
// Push-button start generator: synchronises and debounces an active-low key and turns each
// accepted press into one start pulse, holding a single pending request while the controller is busy.
module input_key_start #(
    parameter int unsigned DEBOUNCE_COUNT = 32'd75000
) (
    input  logic               clk,
    input  logic               rst,
    input_key_start_if.slave   key_if
);

    localparam logic [31:0] LAST_COUNT = 32'(DEBOUNCE_COUNT - 32'd1);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_FILTER   = 2'd1,
        PRESSED        = 2'd2,
        RELEASE_FILTER = 2'd3
    } state_t;

    logic        sync_meta_r;
    logic        sync_key_r;
    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] count_r;
    logic [31:0] count_next_s;
    logic        press_event_s;
    logic        key_state_r;
    logic        key_state_next_s;
    logic        start_r;
    logic        start_next_s;
    logic        pending_r;
    logic        pending_next_s;
    logic        request_s;

    // Two-flop synchroniser; idles at the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            sync_key_r  <= 1'b1;
        end else begin
            sync_meta_r <= key_if.key_in;
            sync_key_r  <= sync_meta_r;
        end
    end

    // Debounce state, stability counter and debounced key level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            count_r     <= 32'd0;
            key_state_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            count_r     <= count_next_s;
            key_state_r <= key_state_next_s;
        end
    end

    // Debounce next-state: any level flip inside a filter window abandons it without an event.
    always_comb begin
        state_next_s  = state_r;
        count_next_s  = count_r;
        press_event_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!sync_key_r) begin
                    state_next_s = PRESS_FILTER;
                    count_next_s = 32'd0;
                end else begin
                    count_next_s = 32'd0;
                end
            end
            PRESS_FILTER: begin
                if (sync_key_r) begin
                    state_next_s = IDLE;
                    count_next_s = 32'd0;
                end else if (count_r == LAST_COUNT) begin
                    state_next_s  = PRESSED;
                    count_next_s  = 32'd0;
                    press_event_s = 1'b1;
                end else begin
                    count_next_s = count_r + 32'd1;
                end
            end
            PRESSED: begin
                if (sync_key_r) begin
                    state_next_s = RELEASE_FILTER;
                    count_next_s = 32'd0;
                end else begin
                    count_next_s = 32'd0;
                end
            end
            RELEASE_FILTER: begin
                if (!sync_key_r) begin
                    state_next_s = PRESSED;
                    count_next_s = 32'd0;
                end else if (count_r == LAST_COUNT) begin
                    state_next_s = IDLE;
                    count_next_s = 32'd0;
                end else begin
                    count_next_s = count_r + 32'd1;
                end
            end
            default: begin
                state_next_s = IDLE;
                count_next_s = 32'd0;
            end
        endcase
        key_state_next_s = (state_next_s == PRESSED) || (state_next_s == RELEASE_FILTER);
    end

    // A new press while a request is already waiting collapses into that one request.
    always_comb begin
        request_s      = press_event_s | pending_r;
        start_next_s   = request_s & key_if.ready;
        pending_next_s = request_s & ~key_if.ready;
    end

    // Registered start pulse and single-entry pending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_r   <= 1'b0;
            pending_r <= 1'b0;
        end else begin
            start_r   <= start_next_s;
            pending_r <= pending_next_s;
        end
    end

    assign key_if.key_state = key_state_r;
    assign key_if.start     = start_r;
    assign key_if.pending   = pending_r;

endmodule

// File: tb/tb_input_key_start.sv
// Directed bench for input_key_start with DEBOUNCE_COUNT=4: press latency, bounce rejection,
// back-pressure, request merging, long hold and asynchronous reset.
module tb_input_key_start;

    localparam int unsigned DC = 32'd4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   start_count;
    int   c0;

    input_key_start_if bus ();

    input_key_start #(.DEBOUNCE_COUNT(DC)) dut (
        .clk    (clk),
        .rst    (rst),
        .key_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses on the falling edge, well clear of the active edge.
    initial start_count = 0;
    always @(negedge clk) begin
        if (bus.start === 1'b1) start_count = start_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks = n_checks + 1;
        if (observed !== expected) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Release the key and let the debouncer settle back to IDLE.
    task automatic release_key();
        bus.key_in = 1'b1;
        tick(10);
    endtask

    // Clean press with ready=1: key_state and start rise at edge 6, start drops at edge 7.
    task automatic clean_press(input string tag);
        int base;
        base = start_count;
        bus.key_in = 1'b0;
        tick(1);
        tick(5);
        check({tag, "_start_e5"}, 32'(bus.start), 32'd0);
        check({tag, "_key_e5"}, 32'(bus.key_state), 32'd0);
        tick(1);
        check({tag, "_start_e6"}, 32'(bus.start), 32'd1);
        check({tag, "_key_e6"}, 32'(bus.key_state), 32'd1);
        check({tag, "_pend_e6"}, 32'(bus.pending), 32'd0);
        tick(1);
        check({tag, "_start_e7"}, 32'(bus.start), 32'd0);
        check({tag, "_key_e7"}, 32'(bus.key_state), 32'd1);
        tick(5);
        check({tag, "_pulses"}, 32'(start_count - base), 32'd1);
        bus.key_in = 1'b1;
        tick(1);
        tick(5);
        check({tag, "_rel_key_r5"}, 32'(bus.key_state), 32'd1);
        tick(1);
        check({tag, "_rel_key_r6"}, 32'(bus.key_state), 32'd0);
        tick(4);
        check({tag, "_rel_nopulse"}, 32'(start_count - base), 32'd1);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus.key_in = 1'b1;
        bus.ready  = 1'b1;
        tick(2);
        check("rst_key_state", 32'(bus.key_state), 32'd0);
        check("rst_start", 32'(bus.start), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        rst = 1'b0;
        tick(4);

        clean_press("clean");

        // Bounce: low for edges 0-2, high at edge 3, low from edge 4 (final falling sample).
        c0 = start_count;
        bus.key_in = 1'b0;
        tick(3);
        bus.key_in = 1'b1;
        tick(1);
        bus.key_in = 1'b0;
        tick(1);
        for (int i = 1; i <= 5; i++) begin
            tick(1);
            check($sformatf("bounce_nostart_f%0d", i), 32'(bus.start), 32'd0);
        end
        tick(1);
        check("bounce_start_f6", 32'(bus.start), 32'd1);
        tick(1);
        check("bounce_start_f7", 32'(bus.start), 32'd0);
        release_key();
        check("bounce_pulses", 32'(start_count - c0), 32'd1);

        // Not ready: pending from edge 6, start issued after ready is sampled at edge 20.
        c0 = start_count;
        bus.ready  = 1'b0;
        bus.key_in = 1'b0;
        tick(1);
        tick(6);
        check("nr_pend_e6", 32'(bus.pending), 32'd1);
        check("nr_start_e6", 32'(bus.start), 32'd0);
        check("nr_key_e6", 32'(bus.key_state), 32'd1);
        tick(13);
        check("nr_pend_e19", 32'(bus.pending), 32'd1);
        check("nr_start_e19", 32'(bus.start), 32'd0);
        bus.ready = 1'b1;
        tick(1);
        check("nr_start_e20", 32'(bus.start), 32'd1);
        check("nr_pend_e20", 32'(bus.pending), 32'd0);
        tick(1);
        check("nr_start_e21", 32'(bus.start), 32'd0);
        release_key();
        check("nr_pulses", 32'(start_count - c0), 32'd1);

        // Merge: two full press/release cycles while not ready yield one request.
        c0 = start_count;
        bus.ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            bus.key_in = 1'b0;
            tick(10);
            bus.key_in = 1'b1;
            tick(10);
        end
        check("merge_pend", 32'(bus.pending), 32'd1);
        check("merge_nostart", 32'(start_count - c0), 32'd0);
        bus.ready = 1'b1;
        tick(1);
        check("merge_start", 32'(bus.start), 32'd1);
        check("merge_pend_clr", 32'(bus.pending), 32'd0);
        tick(1);
        check("merge_start_off", 32'(bus.start), 32'd0);
        tick(5);
        check("merge_pulses", 32'(start_count - c0), 32'd1);

        // Long hold: one pulse only; release symmetric.
        c0 = start_count;
        bus.key_in = 1'b0;
        tick(1000);
        check("hold_key", 32'(bus.key_state), 32'd1);
        bus.key_in = 1'b1;
        tick(1);
        tick(5);
        check("hold_rel_r5", 32'(bus.key_state), 32'd1);
        tick(1);
        check("hold_rel_r6", 32'(bus.key_state), 32'd0);
        tick(4);
        check("hold_pulses", 32'(start_count - c0), 32'd1);

        // Async reset mid-filter, between edges.
        c0 = start_count;
        bus.key_in = 1'b0;
        tick(1);
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mid_key", 32'(bus.key_state), 32'd0);
        check("arst_mid_start", 32'(bus.start), 32'd0);
        check("arst_mid_pend", 32'(bus.pending), 32'd0);
        bus.key_in = 1'b1;
        rst = 1'b0;
        tick(10);
        check("arst_mid_nopulse", 32'(start_count - c0), 32'd0);

        // Async reset while a request is pending discards it.
        bus.ready  = 1'b0;
        bus.key_in = 1'b0;
        tick(1);
        tick(7);
        check("arst_pend_pre", 32'(bus.pending), 32'd1);
        check("arst_pend_key_pre", 32'(bus.key_state), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_pend_key", 32'(bus.key_state), 32'd0);
        check("arst_pend_start", 32'(bus.start), 32'd0);
        check("arst_pend_pend", 32'(bus.pending), 32'd0);
        bus.key_in = 1'b1;
        rst = 1'b0;
        bus.ready = 1'b1;
        tick(10);
        check("arst_pend_discard", 32'(start_count - c0), 32'd0);

        clean_press("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/input_key_start.md
Name: input_key_start

Overview:
- Input-side board peripheral: the stimulus end of the inference path. The LED peripheral reports a result; this block starts the run.
- Takes a raw, bouncy, active-low push-button and synchronises and debounces it.
- Converts each debounced press into exactly one single-cycle `start` pulse for the inference controller.
- Holds at most one pending request while the controller is not ready.

Parameters:
- DEBOUNCE_COUNT, 75000: number of consecutive clk cycles the synchronised key level must stay stable before a press or release is accepted. Legal range is 2 to 2^32-1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  1  raw push-button. 0 = pressed, 1 = released. Asynchronous to clk.
- ready  input  1  inference controller can accept a start. Synchronous to clk.
- key_state  output  1  debounced key level. 1 = pressed.
- start  output  1  one-cycle pulse requesting an inference run.
- pending  output  1  a press has been accepted but `start` has not yet been issued.

Behaviour:
- Reset (asynchronous, while rst=1):
  - Synchroniser stages = 1.
  - FSM = IDLE, counter = 0.
  - key_state = 0, start = 0, pending = 0.
  - Release is synchronous to clk.
- Synchroniser: 2-flop chain on key_in. All following logic uses the second stage only (sync_key).
- Counter: 32 bits. It never counts past DEBOUNCE_COUNT-1.
- FSM states: IDLE, PRESS_FILTER, PRESSED, RELEASE_FILTER.
  - IDLE: if sync_key=0, go to PRESS_FILTER with counter=0.
  - PRESS_FILTER:
    - If sync_key=1, go to IDLE (glitch rejected, no event).
    - Else if counter==DEBOUNCE_COUNT-1, go to PRESSED and raise an internal press_event for that cycle.
    - Else counter+1.
  - PRESSED: if sync_key=1, go to RELEASE_FILTER with counter=0.
  - RELEASE_FILTER:
    - If sync_key=0, go to PRESSED (no new event).
    - Else if counter==DEBOUNCE_COUNT-1, go to IDLE.
    - Else counter+1.
- key_state is registered: 1 in PRESSED and RELEASE_FILTER, 0 otherwise. It updates on the same edge as the state.
- Start/pending logic (registered, evaluated each edge):
  - start_next = (press_event | pending) & ready.
  - pending_next = (press_event | pending) & ~ready.
  - start is never high on two consecutive cycles from a single press.
- Press while pending=1: merged into the existing request. No queue depth beyond 1.
- Press while start is high in the same cycle: impossible by construction, because a press needs DEBOUNCE_COUNT ≥ 2 cycles.
- Latency, measured from edge 0 (first edge sampling key_in=0, key_in then held low), with ready=1:
  - Edge 2: FSM enters PRESS_FILTER.
  - Edge DEBOUNCE_COUNT+2: FSM = PRESSED, key_state=1, start=1.
  - Edge DEBOUNCE_COUNT+3: start=0.
- Release latency is symmetric: key_state=0 at edge DEBOUNCE_COUNT+2 after the first edge sampling key_in=1. Release generates no pulse.
- Holding the key indefinitely produces exactly one start. A new start requires a full debounced release followed by a new debounced press.
- ready dropping after start has been issued has no effect on this block.
- Reset asserted mid-filter or while pending: the request is discarded and all outputs go to 0 immediately.

Test Plan (DEBOUNCE_COUNT=4, ready=1 unless stated):
- Clean press: key_in 1→0 sampled at edge 0 and held → start=1 for exactly the cycle after edge 6; key_state=1 from edge 6; pending stays 0.
- Bounce rejection: key_in low for 3 cycles, high 1 cycle, then low and held → no start during the glitch. Start occurs 6 edges after the final falling sample. Exactly one pulse.
- Not ready: ready=0 during a clean press → pending=1 from edge 6, start=0. Raise ready at edge 20 → start=1 after edge 20, pending=0 after edge 20.
- Merge: ready=0, two complete press/release cycles → pending=1 and only one start pulse once ready=1.
- Long hold: key_in held low 1000 cycles then released → exactly 1 start. key_state returns to 0 6 edges after the first high sample.
- Async reset: assert rst for 1 ns at edge 4 of a press, between clock edges → key_state=0, start=0 and pending=0 immediately. A later clean press behaves as in the first test.
